intra_ang_seq: RTL



---
 rtl/intra_ang_pkg.sv | 82 ++++++++
 rtl/intra_ang_cmdq.sv | 48 ++++
 rtl/intra_ang_seq.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/intra_ang_pkg.sv
// Shared definitions for the angular intra sequencer: mode-to-angle table,
// angle-to-LUT-code map, block size encodings and the FSM state type.
package intra_ang_pkg;

    localparam logic [1:0] SIZE_4  = 2'd0;
    localparam logic [1:0] SIZE_8  = 2'd1;
    localparam logic [1:0] SIZE_16 = 2'd2;
    localparam logic [1:0] SIZE_32 = 2'd3;

    localparam logic [5:0] MODE_ANG_MIN = 6'd2;
    localparam logic [5:0] MODE_ANG_MAX = 6'd34;
    localparam logic [5:0] MODE_HOR_END = 6'd18;

    localparam int CMD_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    typedef struct packed {
        logic [5:0] mode;
        logic [1:0] size;
    } cmd_t;

    // Entries 0/1 (planar/DC) are never used; they only keep the index equal to the mode.
    localparam logic signed [6:0] MODE_ANG [0:34] = '{
        7'sd0,   7'sd0,
        7'sd32,  7'sd26,  7'sd21,  7'sd17,  7'sd13,  7'sd9,   7'sd5,   7'sd2,  7'sd0,
        -7'sd2,  -7'sd5,  -7'sd9,  -7'sd13, -7'sd17, -7'sd21, -7'sd26, -7'sd32,
        -7'sd26, -7'sd21, -7'sd17, -7'sd13, -7'sd9,  -7'sd5,  -7'sd2,  7'sd0,
        7'sd2,   7'sd5,   7'sd9,   7'sd13,  7'sd17,  7'sd21,  7'sd26,  7'sd32
    };

    function automatic logic [4:0] ang_code(input logic signed [6:0] a);
        logic [4:0] c;
        case (a)
            -7'sd2:  c = 5'd0;
            -7'sd5:  c = 5'd1;
            -7'sd9:  c = 5'd2;
            -7'sd13: c = 5'd3;
            -7'sd17: c = 5'd4;
            -7'sd21: c = 5'd5;
            -7'sd26: c = 5'd6;
            -7'sd32: c = 5'd7;
            7'sd2:   c = 5'd9;
            7'sd5:   c = 5'd10;
            7'sd9:   c = 5'd11;
            7'sd13:  c = 5'd12;
            7'sd17:  c = 5'd13;
            7'sd21:  c = 5'd14;
            7'sd26:  c = 5'd15;
            7'sd32:  c = 5'd16;
            default: c = 5'd8;
        endcase
        return c;
    endfunction

    function automatic logic [2:0] last_colgrp(input logic [1:0] sz);
        logic [2:0] l;
        case (sz)
            SIZE_4:  l = 3'd0;
            SIZE_8:  l = 3'd1;
            SIZE_16: l = 3'd3;
            default: l = 3'd7;
        endcase
        return l;
    endfunction

    function automatic logic [4:0] last_row(input logic [1:0] sz);
        logic [4:0] l;
        case (sz)
            SIZE_4:  l = 5'd3;
            SIZE_8:  l = 5'd7;
            SIZE_16: l = 5'd15;
            default: l = 5'd31;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/intra_ang_cmdq.sv
// Two-entry command FIFO placed in front of the sequencer FSM.
// Only instantiated when INTRA_ANG_SEQ_CMDQ_EN is defined.
module intra_ang_cmdq
    import intra_ang_pkg::*;
#(
    parameter int DW = CMD_W
) (
    input  logic          clk,
    input  logic          arst_n,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic          pop,
    output logic [DW-1:0] rdata,
    output logic          empty,
    output logic          full
);
    logic [DW-1:0] mem [2];
    logic          wp;
    logic          rp;
    logic [1:0]    cnt;

    assign rdata = mem[rp];
    assign empty = (cnt == 2'd0);
    assign full  = (cnt == 2'd2);

    // Callers guarantee push only when !full and pop only when !empty.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wp     <= 1'b0;
            rp     <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (push) begin
                mem[wp] <= wdata;
                wp      <= ~wp;
            end
            if (pop) rp <= ~rp;
            case ({push, pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/intra_ang_seq.sv
// Angular intra-prediction sequencer: maps mode to LUT angle code and walks the
// block row by row in 4-sample column groups. INTRA_ANG_SEQ_CMDQ_EN adds a 2-entry command queue.
module intra_ang_seq
    import intra_ang_pkg::*;
#(
    parameter int ANG_W  = 5,
    parameter int YPOS_W = 3,
    parameter int ACC_W  = 12
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [5:0]        cmd_mode,
    input  logic [1:0]        cmd_size,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ANG_W-1:0]  ang,
    output logic [YPOS_W-1:0] yPos,
    output logic [4:0]        row,
    output logic [2:0]        colgrp,
    output logic [7:0]        ref_base,
    output logic [4:0]        frac,
    output logic              is_hor,
    output logic              busy,
    output logic              done,
    output logic              err
);
    state_t                  state;
    logic [1:0]              size_q;
    logic signed [ACC_W-1:0] angle_q;
    logic signed [ACC_W-1:0] acc;
    cmd_t                    src;
    logic                    src_valid;
    logic                    load_en;
    logic                    src_ok;
    logic signed [6:0]       src_ang;

`ifdef INTRA_ANG_SEQ_CMDQ_EN
    logic             q_empty;
    logic             q_full;
    logic [CMD_W-1:0] q_rdata;

    intra_ang_cmdq #(.DW(CMD_W)) u_cmdq (
        .clk    (clk),
        .arst_n (arst_n),
        .push   (cmd_valid && !q_full),
        .wdata  ({cmd_mode, cmd_size}),
        .pop    (load_en),
        .rdata  (q_rdata),
        .empty  (q_empty),
        .full   (q_full)
    );

    assign cmd_ready = !q_full;
    assign src       = cmd_t'(q_rdata);
    assign src_valid = !q_empty;
    // FIN may pick up the next queued command directly, so the FIN cycle is the only gap.
    assign load_en   = src_valid && (state == IDLE || state == FIN);
`else
    logic rdy_q;

    assign cmd_ready = rdy_q;
    assign src       = {cmd_mode, cmd_size};
    assign src_valid = cmd_valid;
    assign load_en   = src_valid && rdy_q;
`endif

    always_comb begin
        src_ok  = (src.mode >= MODE_ANG_MIN) && (src.mode <= MODE_ANG_MAX);
        src_ang = 7'sd0;
        if (src_ok) src_ang = MODE_ANG[src.mode];
    end

    assign yPos     = row[YPOS_W-1:0];
    assign frac     = acc[4:0];
    assign ref_base = 8'(acc >>> 5);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state     <= IDLE;
            size_q    <= '0;
            angle_q   <= '0;
            acc       <= '0;
            ang       <= '0;
            row       <= '0;
            colgrp    <= '0;
            is_hor    <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
`ifndef INTRA_ANG_SEQ_CMDQ_EN
            rdy_q     <= 1'b1;
`endif
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (load_en) begin
                busy   <= 1'b1;
                size_q <= src.size;
`ifndef INTRA_ANG_SEQ_CMDQ_EN
                rdy_q  <= 1'b0;
`endif
                if (src_ok) begin
                    state     <= RUN;
                    out_valid <= 1'b1;
                    angle_q   <= {{(ACC_W-7){src_ang[6]}}, src_ang};
                    acc       <= {{(ACC_W-7){src_ang[6]}}, src_ang};
                    ang       <= ANG_W'(ang_code(src_ang));
                    row       <= '0;
                    colgrp    <= '0;
                    is_hor    <= (src.mode < MODE_HOR_END);
                end else begin
                    state     <= FIN;
                    out_valid <= 1'b0;
                    done      <= 1'b1;
                    err       <= 1'b1;
                end
            end else begin
                case (state)
                    RUN: begin
                        if (out_ready) begin
                            if (colgrp == last_colgrp(size_q)) begin
                                colgrp <= '0;
                                if (row == last_row(size_q)) begin
                                    state     <= FIN;
                                    out_valid <= 1'b0;
                                    done      <= 1'b1;
                                end else begin
                                    // acc tracks (row+1)*angle; bounded by 32*32 so ACC_W never wraps.
                                    row <= row + 5'd1;
                                    acc <= acc + angle_q;
                                end
                            end else begin
                                colgrp <= colgrp + 3'd1;
                            end
                        end
                    end
                    FIN: begin
                        state <= IDLE;
                        busy  <= 1'b0;
`ifndef INTRA_ANG_SEQ_CMDQ_EN
                        rdy_q <= 1'b1;
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
